// File: rtl/btn_press_classifier_if.sv
// Button classifier signal bundle: debounced button inputs and press-type pulses.
// The master drives the debounced button, the slave is the classifier.
interface btn_press_classifier_if;
  logic i_state;
  logic i_press;
  logic i_release;
  logic o_short;
  logic o_long;
  logic o_repeat;
  logic o_held;
  logic o_busy;

  modport master (
    output i_state, i_press, i_release,
    input  o_short, o_long, o_repeat, o_held, o_busy
  );

  modport slave (
    input  i_state, i_press, i_release,
    output o_short, o_long, o_repeat, o_held, o_busy
  );
endinterface

// File: rtl/btn_press_classifier.sv
// Classifies a debounced button into short press, long press and auto-repeat
// pulses using a three-state FSM and one shared hold counter.
module btn_press_classifier #(
  parameter int LONG_CYC   = 100_000_000,
  parameter int REPEAT_CYC = 20_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  btn_press_classifier_if.slave   bus
);

  localparam int MAX_CYC = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int CW      = $clog2(MAX_CYC);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          held_q, held_d;
  logic          busy_q, busy_d;

  // Release beats lost-edge, and both beat a threshold hit in the same cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_press && !bus.i_release) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (bus.i_release) begin
          state_d = IDLE;
          cnt_d   = '0;
          short_d = 1'b1;
        end else if (!bus.i_state) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (bus.i_release || !bus.i_state) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == HELD);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      held_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      held_q   <= held_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.o_short  = short_q;
  assign bus.o_long   = long_q;
  assign bus.o_repeat = repeat_q;
  assign bus.o_held   = held_q;
  assign bus.o_busy   = busy_q;

endmodule
